// File: rtl/icache_refill_unit_pkg.sv
// Shared fetch-side parameters for the L1-I refill path: widths, beat count
// and the refill FSM state encoding.
package icache_refill_unit_pkg;

    localparam int SIZE_PC            = 32;
    localparam int CACHE_WIDTH        = 256;
    localparam int MEM_WIDTH          = 64;
    localparam int BEATS              = CACHE_WIDTH / MEM_WIDTH;
    // Instructions delivered per cache block.
    localparam int INSTRUCTION_BUNDLE = 4;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] REQ   = 3'd1;
    localparam logic [2:0] RECV  = 3'd2;
    localparam logic [2:0] WRITE = 3'd3;
    localparam logic [2:0] HOLD  = 3'd4;

endpackage

// File: rtl/icache_refill_unit_if.sv
// Miss / lower-memory / fill signal bundle for the L1-I refill unit.
// The master side is the refill unit; the slave side is its surroundings.
interface icache_refill_unit_if
    import icache_refill_unit_pkg::*;
#(
    parameter int SIZE_PC     = icache_refill_unit_pkg::SIZE_PC,
    parameter int CACHE_WIDTH = icache_refill_unit_pkg::CACHE_WIDTH,
    parameter int MEM_WIDTH   = icache_refill_unit_pkg::MEM_WIDTH
);

    logic                   miss_i;
    logic [SIZE_PC-1:0]     missAddr_i;
    logic                   memReq_o;
    logic [SIZE_PC-1:0]     memAddr_o;
    logic                   memGnt_i;
    logic                   memValid_i;
    logic [MEM_WIDTH-1:0]   memData_i;
    logic                   wrEnable_o;
    logic [SIZE_PC-1:0]     wrAddr_o;
    logic [CACHE_WIDTH-1:0] instBlock_o;
    logic                   busy_o;

    modport master (
        input  miss_i, missAddr_i, memGnt_i, memValid_i, memData_i,
        output memReq_o, memAddr_o, wrEnable_o, wrAddr_o, instBlock_o, busy_o
    );

    modport slave (
        output miss_i, missAddr_i, memGnt_i, memValid_i, memData_i,
        input  memReq_o, memAddr_o, wrEnable_o, wrAddr_o, instBlock_o, busy_o
    );

endinterface

// File: rtl/icache_refill_unit.sv
// L1-I refill engine: latches a miss, issues one block request, assembles the
// returned beats and writes the block into the cache with a one-cycle strobe.
module icache_refill_unit
    import icache_refill_unit_pkg::*;
#(
    parameter int SIZE_PC     = icache_refill_unit_pkg::SIZE_PC,
    parameter int CACHE_WIDTH = icache_refill_unit_pkg::CACHE_WIDTH,
    parameter int MEM_WIDTH   = icache_refill_unit_pkg::MEM_WIDTH
) (
    input logic                  clk,
    input logic                  reset,
    icache_refill_unit_if.master bus
);

    localparam int NUM_BEATS   = CACHE_WIDTH / MEM_WIDTH;
    localparam int CNT_W       = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam int OFFSET_BITS = $clog2(CACHE_WIDTH / 8);
    localparam logic [SIZE_PC-1:0] OFFSET_MASK = SIZE_PC'((64'd1 << OFFSET_BITS) - 64'd1);

    logic [2:0]             state;
    logic [CNT_W-1:0]       cnt;
    logic [SIZE_PC-1:0]     addr;
    logic [SIZE_PC-1:0]     fillAddr;
    logic [CACHE_WIDTH-1:0] block;
    logic [CACHE_WIDTH-1:0] fillBlock;
    logic [CACHE_WIDTH-1:0] merged;
    logic                   lastBeat;

    // Merging the incoming beat combinationally lets the final beat go straight
    // into the fill register, so the write strobe follows the last beat directly.
    always_comb begin
        merged = block;
        merged[cnt*MEM_WIDTH +: MEM_WIDTH] = bus.memData_i;
    end

    assign lastBeat = bus.memValid_i && (cnt == CNT_W'(NUM_BEATS - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            addr      <= '0;
            block     <= '0;
            fillAddr  <= '0;
            fillBlock <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.miss_i) begin
                        addr  <= bus.missAddr_i & ~OFFSET_MASK;
                        cnt   <= '0;
                        state <= REQ;
                    end
                end
                REQ: begin
                    if (bus.memGnt_i) begin
                        state <= RECV;
                    end
                end
                RECV: begin
                    if (bus.memValid_i) begin
                        block <= merged;
                        cnt   <= cnt + CNT_W'(1);
                        if (lastBeat) begin
                            fillAddr  <= addr;
                            fillBlock <= merged;
                            state     <= WRITE;
                        end
                    end
                end
                WRITE:   state <= HOLD;
                // One dead cycle so the tag update lands before a repeat miss is seen.
                HOLD:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.memReq_o    = (state == REQ);
    assign bus.memAddr_o   = addr;
    assign bus.wrEnable_o  = (state == WRITE);
    assign bus.wrAddr_o    = fillAddr;
    assign bus.instBlock_o = fillBlock;
    assign bus.busy_o      = (state != IDLE);

endmodule

// File: doc/icache_refill_unit.md
ICACHE_REFILL_UNIT -- requirements
Module: icache_refill_unit

Interface
REQ-001 The module SHALL be configured by parameter SIZE_PC, default 32: PC and address width.
REQ-002 The module SHALL be configured by parameter CACHE_WIDTH, default 256: L1-I block width (4 x 64-bit instructions).
REQ-003 The module SHALL be configured by parameter MEM_WIDTH, default 64: lower-memory beat width; BEATS = CACHE_WIDTH/MEM_WIDTH (default 4).
REQ-004 The module SHALL use one clock and a synchronous, active-low reset. Both are listed below, clock first.
REQ-005 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-006 Port: reset  input  1  synchronous reset, active-low (0 = reset).
REQ-007 Port: miss_i  input  1  L1-I miss request, held while the miss persists.
REQ-008 Port: missAddr_i  input  SIZE_PC  miss address, byte address.
REQ-009 Port: memReq_o  output  1  request valid toward lower memory.
REQ-010 Port: memAddr_o  output  SIZE_PC  block-aligned request address.
REQ-011 Port: memGnt_i  input  1  lower memory accepts the request.
REQ-012 Port: memValid_i  input  1  data beat valid.
REQ-013 Port: memData_i  input  MEM_WIDTH  data beat, lowest beat first.
REQ-014 Port: wrEnable_o  output  1  cache fill strobe.
REQ-015 Port: wrAddr_o  output  SIZE_PC  fill address, block-aligned.
REQ-016 Port: instBlock_o  output  CACHE_WIDTH  assembled fill block.
REQ-017 Port: busy_o  output  1  high in every state except IDLE.

Function
REQ-018 The FSM SHALL have the states IDLE, REQ, RECV, WRITE and HOLD.
REQ-019 IDLE: when miss_i=1, the module SHALL latch missAddr_i with its low log2(CACHE_WIDTH/8) bits cleared (default: clear [4:0]), clear the beat counter, and go to REQ.
REQ-020 REQ: memReq_o SHALL be 1 and memAddr_o SHALL equal the latched address. These SHALL stay stable until memGnt_i=1, then the FSM SHALL go to RECV.
REQ-021 RECV: each memValid_i=1 SHALL store memData_i into beat slot [cnt*MEM_WIDTH +: MEM_WIDTH] and increment cnt. Beats arriving in REQ or IDLE SHALL be ignored.
REQ-022 On the beat where cnt=BEATS-1, the FSM SHALL go to WRITE. Gaps between beats (memValid_i=0) SHALL be tolerated for any length.
REQ-023 WRITE: wrEnable_o SHALL be 1 for exactly one cycle, with wrAddr_o equal to the latched address and instBlock_o equal to the assembled block; the FSM then SHALL go to HOLD.
REQ-024 HOLD: the FSM SHALL stay for exactly one cycle, ignore miss_i, then go to IDLE. This suppresses a duplicate refill while the cache tag update takes effect.
REQ-025 Miss-to-fill latency SHALL be 1 (IDLE) + grant wait + beat cycles + 1 (WRITE). The minimum is BEATS+2 cycles, reached when the grant comes on the first REQ cycle and beats are back-to-back.
REQ-026 Changes on miss_i/missAddr_i after the latch in IDLE SHALL NOT affect an in-flight refill; the refill always completes.
REQ-027 Only one outstanding request SHALL exist at a time; memReq_o SHALL be 0 outside REQ.
REQ-028 wrEnable_o SHALL be 0 outside WRITE; instBlock_o and wrAddr_o SHALL hold their last values outside WRITE.

Reset
REQ-029 With reset=0 at a clock edge, the FSM SHALL go to IDLE, cnt=0, the latched address and block SHALL be 0, and memReq_o=0, wrEnable_o=0, busy_o=0.
REQ-030 Reset applied mid-refill SHALL abort the refill with no fill strobe; beats arriving after reset is released SHALL be ignored until a new grant.

Structure
REQ-031 SIZE_PC, CACHE_WIDTH, MEM_WIDTH, BEATS and the state encoding SHALL live in the shared fetch package/defines, alongside INSTRUCTION_BUNDLE.
REQ-032 The design SHALL be a single module with no sub-modules; the beat shift/assembly register SHALL be inline.

Verification
REQ-033 Basic refill: miss_i=1 with missAddr_i=0x0000_1234; grant on the first cycle; beats 0xA..0xD back-to-back -> memAddr_o=0x0000_1220, and wrEnable_o pulses once 6 cycles after the miss with instBlock_o={0xD,0xC,0xB,0xA}.
REQ-034 Grant stall: memGnt_i held low 5 cycles -> memReq_o and memAddr_o stable all 5 cycles; no beat accepted before the grant.
REQ-035 Beat gaps: memValid_i toggling 1,0,0,1,1,0,1 -> 4 beats stored in order; fill happens once, the cycle after the 4th beat.
REQ-036 Persistent miss: miss_i held high through WRITE and HOLD -> no request during HOLD; a new request issues from IDLE on the next cycle only if miss_i is still 1.
REQ-037 Mid-refill reset: reset=0 after 2 beats, then 2 stray beats -> no wrEnable_o, FSM in IDLE, busy_o=0.
REQ-038 Address change: missAddr_i changed to 0x40 during RECV -> fill uses the originally latched address 0x0000_1220.
